uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin scheduler that shares one UART transmitter datapath between N byte-producing requesters. It accepts a byte from one requester via a valid/ready handshake, issues a start strobe with the byte and that requester's parity select to the transmitter, and waits for the transmitter's completion. It then enforces a configurable inter-frame gap, counted in baud ticks, and supervises each frame with a timeout. It sits between the client blocks and the UART TX path, on the same `baud_tick` as the RX/TX datapaths.

## Interface
- `N`, 4 — number of requesters (2..8).
- `GAP_TICKS`, 2 — idle baud ticks inserted after each frame (0 = none).
- `TIMEOUT_TICKS`, 16 — baud ticks allowed between `tx_start` and `tx_done`.

- `clk` in 1 — single clock.
- `rst` in 1 — synchronous, active-high reset.
- `baud_tick` in 1 — one-cycle baud strobe.
- `req_valid` in N — requester i has a byte.
- `req_data` in 8*N — byte of requester i at bits [8i+7:8i].
- `req_psel` in N — parity select of requester i (1 = odd-style, matching the transmitter's `p_sel` encoding).
- `req_ready` out N — one-hot, one-cycle accept pulse.
- `tx_start` out 1 — one-cycle start strobe to the transmitter.
- `tx_data` out 8 — byte to transmit; held from GRANT until the next grant.
- `tx_p_sel` out 1 — parity select; held with `tx_data`.
- `tx_done` in 1 — transmitter completion pulse.
- `grant_id` out clog2(N) — index of the current/last granted requester.
- `busy` out 1 — high in any state except IDLE.
- `tx_timeout` out 1 — one-cycle pulse on frame timeout.

## Operation
- Reset: all outputs 0; state IDLE; RR pointer = N-1, so requester 0 has first priority. Reset mid-frame aborts immediately with no `tx_start`, `req_ready` or `tx_timeout` glitch.
- FSM states are IDLE, GRANT, START, WAIT and GAP.
- **IDLE:** if any `req_valid` is set, the winner is the first set bit searching upward from pointer+1 with wrap. The winner is registered into `grant_id`, then → GRANT.
- **GRANT:**
  - If `req_valid[grant_id]` is still 1: `req_ready[grant_id]`=1 for this cycle; the slice and psel are latched into `tx_data`/`tx_p_sel` at the clock edge; pointer ← `grant_id`; → START.
  - If `req_valid[grant_id]` has dropped: no ready, pointer unchanged, → IDLE.
- **START:** `tx_start`=1 for exactly one cycle; timeout counter cleared; → WAIT.
- **WAIT:**
  - `tx_done` → GAP.
  - Otherwise each `baud_tick` increments the counter. When the counter reaches `TIMEOUT_TICKS`, `tx_timeout` pulses and → GAP.
  - `tx_done` in the same cycle as the terminal tick means done wins, with no timeout.
- **GAP:**
  - Counts `baud_tick` up to `GAP_TICKS`, then → IDLE.
  - If `GAP_TICKS`=0, GAP → IDLE on the next cycle.
- `req_valid` changes outside IDLE/GRANT are ignored. Requesters must hold data until ready.
- Counter width is clog2(max(`GAP_TICKS`,`TIMEOUT_TICKS`)+1). The counter is shared by WAIT and GAP and cleared on each entry.

## Timing
- Grant latency: `req_valid` seen in IDLE at cycle T → `req_ready` at T+1 → `tx_start` at T+2.
- `tx_start` is never asserted while the transmitter's previous frame is pending (WAIT/GAP exclusion).
- Minimum cycles between consecutive `tx_start` strobes = 3 + WAIT duration + GAP duration (≥ 1 cycle in GAP).
- `busy` rises at T+1 (registered from state), falls on the cycle IDLE is re-entered.
- Fairness: with all N requesters continuously valid, grants rotate 0,1,…,N-1,0 — no requester waits more than N-1 frames.

## Structure
- Shared package `uart_pkg`:
  - Holds the FSM state typedef (`tx_arb_state_t`).
  - Holds the default `GAP_TICKS`/`TIMEOUT_TICKS` constants.
  - Holds the `clog2` helper, used here and by the RX/TX datapaths.
- One combinational sub-module `rr_pick`:
  - Inputs: `req` [N] and pointer.
  - Outputs: `winner` index and `any`.
  - Implemented by rotate, priority-encode, un-rotate.

## Test plan
- Reset then single requester: `req_valid`=0010, data1=0xA5, psel1=1 → `req_ready`=0010 at T+1, `tx_start` at T+2 with `tx_data`=0xA5, `tx_p_sel`=1, `grant_id`=1.
- All four valid continuously, `tx_done` 10 ticks after each start, `GAP_TICKS`=2 → grant order 0,1,2,3,0. Exactly 2 `baud_tick`s separate each `tx_done` from the next `req_ready`.
- `tx_done` never returned, `TIMEOUT_TICKS`=16 → `tx_timeout` pulses once on the 16th tick after `tx_start`; the next grant proceeds normally.
- `tx_done` coincident with the 16th tick → no `tx_timeout`, normal GAP.
- Requester drops valid in GRANT cycle → no `req_ready`, no `tx_start`, pointer unchanged; re-assert → same requester granted.
- `rst` asserted in WAIT → next cycle all outputs 0 and `busy`=0; the first grant after release goes to requester 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART RX/TX datapaths and the TX arbiter:
// arbiter state encoding, default timing constants and a width helper.
package uart_pkg;

  localparam int unsigned GapTicksDefault     = 2;
  localparam int unsigned TimeoutTicksDefault = 16;

  typedef enum logic [2:0] {
    StIdle,
    StGrant,
    StStart,
    StWait,
    StGap
  } tx_arb_state_t;

  // Ceiling log2; returns 0 for values 0 and 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side valid/ready bundle plus the transmitter start/done handshake.
// The master modport is the arbiter; the slave modport is clients plus transmitter.
interface uart_tx_arbiter_if #(
  parameter int unsigned N = 4
) ();

  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_psel;
  logic [N-1:0]   req_ready;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tx_p_sel;
  logic           tx_done;

  modport master (
    input  req_valid,
    input  req_data,
    input  req_psel,
    input  tx_done,
    output req_ready,
    output tx_start,
    output tx_data,
    output tx_p_sel
  );

  modport slave (
    output req_valid,
    output req_data,
    output req_psel,
    output tx_done,
    input  req_ready,
    input  tx_start,
    input  tx_data,
    input  tx_p_sel
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after the
// pointer, with wrap. Rotate so the search starts at bit 0, encode, un-rotate.
module rr_pick
  import uart_pkg::*;
#(
  parameter  int unsigned N   = 4,
  localparam int unsigned IdW = clog2(N)
) (
  input  logic [N-1:0]   i_req,
  input  logic [IdW-1:0] i_ptr,
  output logic [IdW-1:0] o_winner,
  output logic           o_any
);

  logic [N-1:0]   w_rot;
  logic [IdW-1:0] w_off;
  int unsigned    w_base;

  always_comb begin
    w_base = (32'(i_ptr) + 32'd1) % N;
    w_rot  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_rot[i] = i_req[IdW'((i + w_base) % N)];
    end
    // Lowest set bit of the rotated vector is the highest-priority request.
    w_off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = IdW'(i);
    end
    o_winner = IdW'((32'(w_off) + w_base) % N);
    o_any    = |i_req;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter between N requesters,
// with a baud-tick inter-frame gap and a per-frame completion timeout.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int unsigned N             = 4,
  parameter  int unsigned GAP_TICKS     = GapTicksDefault,
  parameter  int unsigned TIMEOUT_TICKS = TimeoutTicksDefault,
  localparam int unsigned IdW           = clog2(N)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_baud_tick,
  uart_tx_arbiter_if.master tx_bus,
  output logic [IdW-1:0]    o_grant_id,
  output logic              o_busy,
  output logic              o_tx_timeout
);

  localparam int unsigned MaxTicks = (GAP_TICKS > TIMEOUT_TICKS) ? GAP_TICKS : TIMEOUT_TICKS;
  localparam int unsigned CntW     = (clog2(MaxTicks + 1) > 0) ? clog2(MaxTicks + 1) : 1;

  tx_arb_state_t   r_state;
  tx_arb_state_t   w_state_d;
  logic [IdW-1:0]  r_ptr;
  logic [IdW-1:0]  r_grant_id;
  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_d;
  logic [7:0]      r_tx_data;
  logic            r_tx_p_sel;

  logic [IdW-1:0]  w_winner;
  logic            w_any;
  logic            w_grant_ok;
  logic            w_wait_last;
  logic            w_gap_last;

  rr_pick #(
    .N (N)
  ) u_rr_pick (
    .i_req    (tx_bus.req_valid),
    .i_ptr    (r_ptr),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  assign w_grant_ok  = tx_bus.req_valid[r_grant_id];
  assign w_wait_last = i_baud_tick && ((32'(r_cnt) + 32'd1) >= TIMEOUT_TICKS);
  assign w_gap_last  = (GAP_TICKS == 0) ||
                       (i_baud_tick && ((32'(r_cnt) + 32'd1) >= GAP_TICKS));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:  if (w_any) w_state_d = StGrant;
      StGrant: w_state_d = w_grant_ok ? StStart : StIdle;
      StStart: w_state_d = StWait;
      // Done takes precedence over a coincident terminal tick.
      StWait:  if (tx_bus.tx_done || w_wait_last) w_state_d = StGap;
      StGap:   if (w_gap_last) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    tx_bus.req_ready = '0;
    tx_bus.tx_start  = 1'b0;
    o_tx_timeout     = 1'b0;
    case (r_state)
      StGrant: tx_bus.req_ready[r_grant_id] = w_grant_ok;
      StStart: tx_bus.tx_start = 1'b1;
      StWait:  o_tx_timeout = w_wait_last && !tx_bus.tx_done;
      default: ;
    endcase
  end

  // Shared tick counter: cleared on every state change, counts only in WAIT/GAP.
  always_comb begin
    w_cnt_d = '0;
    if ((w_state_d == r_state) && ((r_state == StWait) || (r_state == StGap))) begin
      w_cnt_d = i_baud_tick ? r_cnt + 1'b1 : r_cnt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr      <= IdW'(N - 1);
      r_grant_id <= '0;
      r_cnt      <= '0;
      r_tx_data  <= '0;
      r_tx_p_sel <= 1'b0;
    end else begin
      r_cnt <= w_cnt_d;
      if ((r_state == StIdle) && w_any) begin
        r_grant_id <= w_winner;
      end
      if ((r_state == StGrant) && w_grant_ok) begin
        r_ptr      <= r_grant_id;
        r_tx_data  <= tx_bus.req_data[{r_grant_id, 3'b000} +: 8];
        r_tx_p_sel <= tx_bus.req_psel[r_grant_id];
      end
    end
  end

  assign tx_bus.tx_data  = r_tx_data;
  assign tx_bus.tx_p_sel = r_tx_p_sel;
  assign o_grant_id      = r_grant_id;
  assign o_busy          = (r_state != StIdle);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: requester and transmitter models
// drive the bus, expected frames are queued and compared on each tx_start.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int unsigned N          = 4;
  localparam int unsigned Gap        = 2;
  localparam int unsigned Tmo        = 16;
  localparam int unsigned IdW        = clog2(N);
  localparam int          TickPeriod = 4;

  typedef struct {
    int         id;
    logic [7:0] data;
    logic       psel;
  } frame_t;

  logic           clk       = 1'b0;
  logic           rst       = 1'b1;
  logic           baud_tick = 1'b0;
  logic [IdW-1:0] grant_id;
  logic           busy;
  logic           tx_timeout;

  uart_tx_arbiter_if #(.N(N)) bus ();

  uart_tx_arbiter #(
    .N             (N),
    .GAP_TICKS     (Gap),
    .TIMEOUT_TICKS (Tmo)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_baud_tick  (baud_tick),
    .tx_bus       (bus),
    .o_grant_id   (grant_id),
    .o_busy       (busy),
    .o_tx_timeout (tx_timeout)
  );

  always #5 clk = ~clk;

  int           n_cmp = 0;
  int           n_err = 0;
  int           cyc = 0;
  logic         rst_drv = 1'b1;
  logic [N-1:0] en = '0;
  int           pend [N];
  logic [7:0]   cur_data [N];
  logic         cur_psel [N];
  int           done_after = 10;
  bit           frame_open = 1'b0;
  int           frame_ticks = 0;
  bit           gap_meas = 1'b0;
  int           gap_ticks = 0;
  int           n_timeout = 0;
  int           n_start = 0;
  logic [N-1:0] ready_seen = '0;
  frame_t       exp_q [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int id, input logic [7:0] data, input logic psel);
    frame_t f;
    f.id   = id;
    f.data = data;
    f.psel = psel;
    exp_q.push_back(f);
  endtask

  function automatic bit pending_any();
    for (int i = 0; i < N; i++) begin
      if (en[i] && (pend[i] > 0)) return 1'b1;
    end
    return 1'b0;
  endfunction

  // One clock: drive inputs just after the rising edge, observe on the falling edge.
  task automatic cycle();
    logic [N-1:0]   v;
    logic [8*N-1:0] d;
    logic [N-1:0]   p;
    frame_t         f;
    @(posedge clk);
    #1;
    cyc++;
    rst = rst_drv;
    for (int i = 0; i < N; i++) begin
      if (ready_seen[i]) begin
        pend[i]--;
        cur_data[i] += 8'h11;
        cur_psel[i] = ~cur_psel[i];
      end
      v[i]        = en[i] && (pend[i] > 0);
      d[8*i +: 8] = cur_data[i];
      p[i]        = cur_psel[i];
    end
    bus.req_valid = v;
    bus.req_data  = d;
    bus.req_psel  = p;
    baud_tick     = ((cyc % TickPeriod) == 0);
    bus.tx_done   = 1'b0;
    if (gap_meas && baud_tick) gap_ticks++;
    if (frame_open && baud_tick) begin
      frame_ticks++;
      if ((done_after != 0) && (frame_ticks == done_after)) begin
        bus.tx_done = 1'b1;
        frame_open  = 1'b0;
        gap_meas    = 1'b1;
        gap_ticks   = 0;
      end
    end
    if (rst_drv) begin
      frame_open = 1'b0;
      gap_meas   = 1'b0;
    end
    @(negedge clk);
    if (bus.tx_start) begin
      n_start++;
      check_eq("start_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        f = exp_q.pop_front();
        check_eq("start_id", 32'(grant_id), f.id);
        check_eq("start_data", 32'(bus.tx_data), 32'(f.data));
        check_eq("start_psel", 32'(bus.tx_p_sel), 32'(f.psel));
        check_eq("ready_before_start", 32'(ready_seen), 32'd1 << f.id);
      end
      frame_open  = 1'b1;
      frame_ticks = 0;
    end
    if (tx_timeout) begin
      n_timeout++;
      check_eq("timeout_tick", frame_ticks, Tmo);
      frame_open = 1'b0;
    end
    if (bus.req_ready != '0) begin
      check_eq("ready_onehot", 32'($onehot(bus.req_ready)), 1);
      if (gap_meas) begin
        check_eq("gap_ticks", gap_ticks, Gap);
        gap_meas = 1'b0;
      end
    end
    ready_seen = bus.req_ready;
  endtask

  task automatic drain(input string tag, input int budget);
    int k;
    k = 0;
    while ((busy || (exp_q.size() != 0) || pending_any()) && (k < budget)) begin
      cycle();
      k++;
    end
    check_eq(tag, 32'((exp_q.size() == 0) && !busy), 1);
    gap_meas = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"}, 32'(busy), 0);
    check_eq({tag, "_start"}, 32'(bus.tx_start), 0);
    check_eq({tag, "_ready"}, 32'(bus.req_ready), 0);
    check_eq({tag, "_timeout"}, 32'(tx_timeout), 0);
    check_eq({tag, "_grant_id"}, 32'(grant_id), 0);
    check_eq({tag, "_tx_data"}, 32'(bus.tx_data), 0);
    check_eq({tag, "_tx_psel"}, 32'(bus.tx_p_sel), 0);
  endtask

  initial begin
    int           a;
    int           rc;
    int           sc;
    int           base;
    logic [N-1:0] rdy_val;
    logic         any_rdy;

    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_psel  = '0;
    bus.tx_done   = 1'b0;
    for (int i = 0; i < N; i++) begin
      pend[i]     = 0;
      cur_data[i] = 8'(8'h30 + 16 * i);
      cur_psel[i] = 1'(i % 2);
    end

    // Reset state
    repeat (3) cycle();
    check_reset_outputs("rst");
    rst_drv = 1'b0;
    repeat (2) cycle();

    // Single requester: latency and latched byte/parity
    cur_data[1] = 8'hA5;
    cur_psel[1] = 1'b1;
    pend[1]     = 1;
    en          = 4'b0010;
    push_exp(1, 8'hA5, 1'b1);
    cycle();
    a = cyc;
    check_eq("t1_busy_at_T", 32'(busy), 0);
    rc      = 0;
    sc      = 0;
    rdy_val = '0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if ((bus.req_ready != '0) && (rc == 0)) begin
        rc      = cyc;
        rdy_val = bus.req_ready;
      end
      if (bus.tx_start && (sc == 0)) sc = cyc;
    end
    check_eq("t1_ready_latency", rc - a, 1);
    check_eq("t1_ready_value", 32'(rdy_val), 32'b0010);
    check_eq("t1_start_latency", sc - a, 2);
    drain("t1_drain", 300);

    // Fairness after reset: 0,1,2,3 then 0,1,2,3 with exact gap
    rst_drv = 1'b1;
    cycle();
    rst_drv = 1'b0;
    cycle();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < N; i++) begin
        push_exp(i, 8'(cur_data[i] + 8'(r * 8'h11)), cur_psel[i] ^ 1'(r));
      end
    end
    for (int i = 0; i < N; i++) pend[i] = 2;
    en = '1;
    drain("t2_drain", 3000);

    // No tx_done: one timeout on the 16th tick, next frame normal
    done_after = 0;
    base       = n_timeout;
    pend[2]    = 2;
    en         = 4'b0100;
    push_exp(2, cur_data[2], cur_psel[2]);
    push_exp(2, cur_data[2] + 8'h11, ~cur_psel[2]);
    for (int k = 0; (k < 300) && (n_timeout == base); k++) cycle();
    check_eq("t3_timeout_seen", n_timeout - base, 1);
    done_after = 10;
    drain("t3_drain", 1000);
    check_eq("t3_timeout_once", n_timeout - base, 1);

    // tx_done coincident with the terminal tick: no timeout
    done_after = Tmo;
    base       = n_timeout;
    pend[3]    = 2;
    en         = 4'b1000;
    push_exp(3, cur_data[3], cur_psel[3]);
    push_exp(3, cur_data[3] + 8'h11, ~cur_psel[3]);
    drain("t4_drain", 1000);
    check_eq("t4_no_timeout", n_timeout - base, 0);
    done_after = 10;

    // Valid dropped in GRANT: no ready, no start, pointer kept
    pend[1] = 1;
    en      = 4'b0010;
    push_exp(1, cur_data[1], cur_psel[1]);
    drain("t5_setup_drain", 300);
    pend[2] = 1;
    en      = 4'b0100;
    cycle();
    en = '0;
    cycle();
    check_eq("t5_no_ready_in_grant", 32'(bus.req_ready), 0);
    check_eq("t5_busy_in_grant", 32'(busy), 1);
    base    = n_start;
    any_rdy = 1'b0;
    repeat (6) begin
      cycle();
      any_rdy |= (bus.req_ready != '0);
    end
    check_eq("t5_no_ready_after_drop", 32'(any_rdy), 0);
    check_eq("t5_no_start_after_drop", n_start - base, 0);
    check_eq("t5_idle_after_drop", 32'(busy), 0);
    pend[3] = 1;
    en      = 4'b1100;
    push_exp(2, cur_data[2], cur_psel[2]);
    push_exp(3, cur_data[3], cur_psel[3]);
    drain("t5_drain", 600);

    // Reset while waiting for tx_done
    pend[2] = 1;
    en      = 4'b0100;
    push_exp(2, cur_data[2], cur_psel[2]);
    base = n_start;
    for (int k = 0; (k < 20) && (n_start == base); k++) cycle();
    check_eq("t6_started", n_start - base, 1);
    repeat (4) cycle();
    check_eq("t6_busy_in_wait", 32'(busy), 1);
    en      = '0;
    rst_drv = 1'b1;
    cycle();
    rst_drv = 1'b0;
    cycle();
    check_reset_outputs("t6_rst");
    pend[0] = 1;
    pend[3] = 1;
    en      = 4'b1001;
    push_exp(0, cur_data[0], cur_psel[0]);
    push_exp(3, cur_data[3], cur_psel[3]);
    drain("t6_drain", 600);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
